// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU opcodes, bubble control word and
// forward-select encoding used by the ID/EX stage and its forwarding muxes.
package pipeline_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  // A bubble must never write the register file or touch memory.
  localparam ex_ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0,
                                       mem_write: 1'b0, mem_to_reg: 1'b0};

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats the
// register-file value; register 0 is never forwarded.
module fwd_mux
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_reg,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     fwd_data
);

  logic     exmem_hit_s;
  logic     memwb_hit_s;
  fwd_sel_e sel_s;

  assign exmem_hit_s = exmem_reg_write && (exmem_rd != {REG_ADDR_W{1'b0}}) && (exmem_rd == src_reg);
  assign memwb_hit_s = memwb_reg_write && (memwb_rd != {REG_ADDR_W{1'b0}}) && (memwb_rd == src_reg);

  // Forward source selection, newest producer first
  always_comb begin
    sel_s = FWD_RF;
    if (exmem_hit_s) begin
      sel_s = FWD_EXMEM;
    end else if (memwb_hit_s) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  // Forwarded data mux
  always_comb begin
    fwd_data = rf_data;
    case (sel_s)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      FWD_RF:    fwd_data = rf_data;
      default:   fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use bubble insertion, stall and flush.
// Optional ID_EX_BUBBLE_COUNT_EN adds a 32-bit bubble_count output.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_read_data_1,
  input  logic [DATA_W-1:0]     id_read_data_2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [CTRL_W-1:0]     id_alu_control,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     Read_data_1,
  output logic [DATA_W-1:0]     Data_2,
  output logic [CTRL_W-1:0]     ALU_control,
  output logic [REG_ADDR_W-1:0] ex_write_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  load_use_stall
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [31:0]           bubble_count
`endif
);

  logic                  valid_r;
  logic [CTRL_W-1:0]     alu_ctrl_r;
  logic [REG_ADDR_W-1:0] write_reg_r;
  ex_ctrl_t              ctrl_r;
  logic [REG_ADDR_W-1:0] rs_r;
  logic [REG_ADDR_W-1:0] rt_r;
  logic [DATA_W-1:0]     rd1_r;
  logic [DATA_W-1:0]     rd2_r;
  logic [DATA_W-1:0]     imm_r;
  logic                  alu_src_r;
  logic                  hazard_s;
  logic [DATA_W-1:0]     rs_fwd_s;
  logic [DATA_W-1:0]     rt_fwd_s;

  assign hazard_s = valid_r && ctrl_r.mem_read && (write_reg_r != {REG_ADDR_W{1'b0}}) && id_valid &&
                    ((write_reg_r == id_rs) || (write_reg_r == id_rt));
  // A held stage must not also inject a bubble.
  assign load_use_stall = hazard_s && !stall;

  // Stage register: reset > flush > stall > load-use bubble > normal load
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && load_use_stall)) begin
      valid_r     <= 1'b0;
      alu_ctrl_r  <= CTRL_W'(ALU_ADD);
      write_reg_r <= {REG_ADDR_W{1'b0}};
      ctrl_r      <= CTRL_BUBBLE;
      rs_r        <= {REG_ADDR_W{1'b0}};
      rt_r        <= {REG_ADDR_W{1'b0}};
      rd1_r       <= {DATA_W{1'b0}};
      rd2_r       <= {DATA_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
      alu_src_r   <= 1'b0;
    end else if (!stall) begin
      valid_r     <= id_valid;
      alu_ctrl_r  <= id_alu_control;
      write_reg_r <= id_reg_dst ? id_rd : id_rt;
      ctrl_r      <= '{reg_write:  id_reg_write  & id_valid,
                       mem_read:   id_mem_read   & id_valid,
                       mem_write:  id_mem_write  & id_valid,
                       mem_to_reg: id_mem_to_reg & id_valid};
      rs_r        <= id_rs;
      rt_r        <= id_rt;
      rd1_r       <= id_read_data_1;
      rd2_r       <= id_read_data_2;
      imm_r       <= id_imm;
      alu_src_r   <= id_alu_src;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_reg         (rs_r),
    .rf_data         (rd1_r),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (rs_fwd_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_reg         (rt_r),
    .rf_data         (rd2_r),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (rt_fwd_s)
  );

  assign ex_valid      = valid_r;
  assign ALU_control   = alu_ctrl_r;
  assign ex_write_reg  = write_reg_r;
  assign ex_reg_write  = ctrl_r.reg_write;
  assign ex_mem_read   = ctrl_r.mem_read;
  assign ex_mem_write  = ctrl_r.mem_write;
  assign ex_mem_to_reg = ctrl_r.mem_to_reg;
  assign Read_data_1   = rs_fwd_s;
  assign Data_2        = alu_src_r ? imm_r : rt_fwd_s;
  assign ex_store_data = rt_fwd_s;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic        bubble_load_s;
  logic [31:0] bubble_count_r;

  assign bubble_load_s = flush || load_use_stall;

  // Bubble counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_r <= 32'd0;
    end else if (bubble_load_s) begin
      bubble_count_r <= bubble_count_r + 32'd1;
    end
  end

  assign bubble_count = bubble_count_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX-slot snapshots.
module tb_id_ex_stage;

  typedef logic [109:0] obs_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_read_data_1, id_read_data_2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
  logic [31:0] Read_data_1, Data_2, ex_store_data;
  logic [2:0]  ALU_control;
  logic [4:0]  ex_write_reg;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count;
`endif

  int   errors = 0;
  int   checks = 0;
  int   exp_bubbles = 0;
  obs_t exp_q[$];
  obs_t got, want;
  obs_t bubble;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(3)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .Read_data_1(Read_data_1), .Data_2(Data_2), .ALU_control(ALU_control),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
`ifdef ID_EX_BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  function automatic obs_t mk(logic v, logic [31:0] rd1, logic [31:0] d2, logic [2:0] alu,
                              logic [4:0] wr, logic rw, logic mr, logic mw, logic m2r,
                              logic [31:0] st, logic lus);
    return {v, rd1, d2, alu, wr, rw, mr, mw, m2r, st, lus};
  endfunction

  function automatic obs_t obs();
    return {ex_valid, Read_data_1, Data_2, ALU_control, ex_write_reg, ex_reg_write,
            ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_store_data, load_use_stall};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_read_data_1 = 32'd0; id_read_data_2 = 32'd0; id_imm = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_alu_control = 3'd2;
    id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic set_id(logic v, logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                        logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [2:0] alu,
                        logic asrc, logic rdst, logic rw, logic mr, logic mw, logic m2r);
    id_valid = v; id_read_data_1 = rd1; id_read_data_2 = rd2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_control = alu;
    id_alu_src = asrc; id_reg_dst = rdst; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(bubble);
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_state: got %h expected %h", got, want); end
`ifdef ID_EX_BUBBLE_COUNT_EN
    checks++;
    if (bubble_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bubble_count); end
`endif
  endtask

  task automatic test_basic();
    logic [2:0]  alu_tab [4] = '{3'd6, 3'd0, 3'd7, 3'd1};
    logic [31:0] rd1, rd2, imm;
    logic        v, asrc, rdst, mw, m2r;
    logic [4:0]  rt, rd;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      rd1 = (i == 0) ? 32'd5 : $urandom;
      rd2 = (i == 0) ? 32'd3 : $urandom;
      imm = $urandom;
      v = (i != 2);
      asrc = (i == 1) || (i == 3);
      rdst = (i == 0) || (i == 2);
      mw = (i == 1);
      m2r = (i == 3);
      rt = 5'(i + 2);
      rd = 5'(i + 10);
      set_id(v, rd1, rd2, imm, 5'd1, rt, rd, alu_tab[i], asrc, rdst, 1'b1, 1'b0, mw, m2r);
      exp_q.push_back(mk(v, rd1, asrc ? imm : rd2, alu_tab[i], rdst ? rd : rt,
                         v, 1'b0, mw & v, m2r & v, rd2, 1'b0));
      tick();
      got = obs(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL basic[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    set_id(1'b1, 32'h11, 32'h22, 32'h0, 5'd4, 5'd5, 5'd6, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1;
    checks++;
    if (Read_data_1 !== 32'hAA) begin errors++; $display("FAIL fwd_exmem: got %h expected aa", Read_data_1); end
    exmem_reg_write = 1'b0;
    #1;
    checks++;
    if (Read_data_1 !== 32'hBB) begin errors++; $display("FAIL fwd_memwb: got %h expected bb", Read_data_1); end
    memwb_reg_write = 1'b0;
    #1;
    checks++;
    if (Read_data_1 !== 32'h11) begin errors++; $display("FAIL fwd_none: got %h expected 11", Read_data_1); end
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hCC;
    #1;
    checks++;
    if ({Data_2, ex_store_data} !== {32'hCC, 32'hCC}) begin
      errors++; $display("FAIL fwd_rt: got %h/%h expected cc/cc", Data_2, ex_store_data);
    end
    clear_inputs();
    set_id(1'b1, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd6, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    #1;
    checks++;
    if (Read_data_1 !== 32'h33) begin errors++; $display("FAIL fwd_reg0: got %h expected 33", Read_data_1); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_id(1'b1, 32'h10, 32'h20, 32'h0, 5'd1, 5'd8, 5'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(mk(1'b1, 32'h10, 32'h20, 3'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1));
    tick();
    set_id(1'b1, 32'h44, 32'h55, 32'h0, 5'd8, 5'd9, 5'd10, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL lu_detect: got %h expected %h", got, want); end
    exp_q.push_back(bubble);
    exp_bubbles++;
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL lu_bubble: got %h expected %h", got, want); end
    exp_q.push_back(mk(1'b1, 32'h44, 32'h55, 3'd2, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 1'b0));
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL lu_reload: got %h expected %h", got, want); end
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_reg0: got %b expected 0", load_use_stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    obs_t exp_a;
    clear_inputs();
    set_id(1'b1, 32'h61, 32'h62, 32'h0, 5'd3, 5'd8, 5'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    id_rs = 5'd8;
    exp_a = mk(1'b1, 32'h61, 32'h62, 3'd1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h62, 1'b0);
    for (int i = 0; i < 3; i++) begin
      id_read_data_1 = $urandom; id_read_data_2 = $urandom; id_imm = $urandom;
      id_alu_control = 3'(i + 5); id_rt = 5'(i + 20); id_rd = 5'(i + 12); id_reg_dst = 1'b1;
      id_mem_write = 1'b1;
      exp_q.push_back(exp_a);
      tick();
      got = obs(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, got, want); end
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    checks++;
    if (bubble_count !== 32'(exp_bubbles)) begin
      errors++; $display("FAIL stall_count: got %0d expected %0d", bubble_count, exp_bubbles);
    end
`endif
    stall = 1'b0;
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL stall_release_lu: got %b expected 1", load_use_stall); end
    exp_q.push_back(bubble);
    exp_bubbles++;
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL stall_bubble: got %h expected %h", got, want); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    set_id(1'b1, 32'h71, 32'h72, 32'h0, 5'd2, 5'd3, 5'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    exp_q.push_back(bubble);
    exp_bubbles++;
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL flush_bubble: got %h expected %h", got, want); end
    flush = 1'b0;
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 32'h81, 32'h82, 32'h0, 5'd8, 5'd9, 5'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    exp_q.push_back(bubble);
    exp_bubbles++;
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL flush_lu_bubble: got %h expected %h", got, want); end
    flush = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h81, 32'h82, 3'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h82, 1'b0));
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL flush_lu_reload: got %h expected %h", got, want); end
    stall = 1'b1; flush = 1'b1;
    exp_q.push_back(bubble);
    exp_bubbles++;
    tick();
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL flush_over_stall: got %h expected %h", got, want); end
`ifdef ID_EX_BUBBLE_COUNT_EN
    checks++;
    if (bubble_count !== 32'(exp_bubbles)) begin
      errors++; $display("FAIL bubble_count: got %0d expected %0d", bubble_count, exp_bubbles);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    set_id(1'b1, 32'h91, 32'h92, 32'h0, 5'd2, 5'd3, 5'd4, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    stall = 1'b1; reset = 1'b1;
    exp_q.push_back(bubble);
    exp_bubbles = 0;
    tick();
    reset = 1'b0; stall = 1'b0; id_valid = 1'b0;
    got = obs(); want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_mid_stall: got %h expected %h", got, want); end
`ifdef ID_EX_BUBBLE_COUNT_EN
    checks++;
    if (bubble_count !== 32'(exp_bubbles)) begin
      errors++; $display("FAIL reset_count_clear: got %0d expected %0d", bubble_count, exp_bubbles);
    end
`endif
  endtask

  initial begin
    bubble = mk(1'b0, 32'd0, 32'd0, 3'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
